// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed seven-segment display driver.
// Scans DIGITS hex digits onto a shared active-low segment bus with
// active-low anodes, full 0-F glyph set, optional leading-zero blanking
// and frame-synchronous (tear-free) value updates via a pending/display
// register pair.
// Optional feature macro: SEG7_BRIGHTNESS_EN adds i_bright[3:0] and a
// per-slot duty window; when undefined the duty cycle is full.
module seg7_scan_driver #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [4*DIGITS-1:0] i_value,
   input  logic [DIGITS-1:0]   i_dp,
   input  logic                i_load,
   input  logic                i_blank_lz,
`ifdef SEG7_BRIGHTNESS_EN
   input  logic [3:0]          i_bright,
`endif
   output logic [6:0]          o_seg,
   output logic                o_dp,
   output logic [DIGITS-1:0]   o_an,
   output logic                o_frame
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   // Active-low glyph for one hex nibble, bit order g..a.
   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'b1000000;
         4'h1:    g = 7'b1111001;
         4'h2:    g = 7'b0100100;
         4'h3:    g = 7'b0110000;
         4'h4:    g = 7'b0011001;
         4'h5:    g = 7'b0010010;
         4'h6:    g = 7'b0000010;
         4'h7:    g = 7'b1111000;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0010000;
         4'hA:    g = 7'b0001000;
         4'hB:    g = 7'b0000011;
         4'hC:    g = 7'b1000110;
         4'hD:    g = 7'b0100001;
         4'hE:    g = 7'b0000110;
         4'hF:    g = 7'b0001110;
         default: g = 7'b1111111;
      endcase
      return g;
   endfunction

   // Scan timing state
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                wrap_q;
   logic                wrap_s;
   logic                slot_end_s;

   // Value path
   logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
   logic [DIGITS-1:0]   pend_dp_q,  pend_dp_d;
   logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
   logic [DIGITS-1:0]   disp_dp_q,  disp_dp_d;

   // Output stage
   logic [6:0]          seg_q, seg_d;
   logic                dp_q,  dp_d;
   logic [DIGITS-1:0]   an_q,  an_d;
   logic                frame_q, frame_d;

   logic [3:0]          nib_s;
   logic                dp_sel_s;
   logic                lz_s;
   logic                blank_s;
   logic                on_s;
   logic [DIGITS-1:0]   an_sel_s;

`ifdef SEG7_BRIGHTNESS_EN
   localparam int PW = CNT_W + 5;
   logic [PW-1:0]       duty_lhs_s;
   logic [PW-1:0]       duty_rhs_s;
`endif

   // Next-state for the refresh counter, digit index and wrap detection.
   always_comb begin
      slot_end_s = (cnt_q == CNT_LAST);
      wrap_s     = 1'b0;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      if (slot_end_s) begin
         cnt_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            wrap_s = 1'b1;
         end else begin
            idx_d = idx_q + IDX_ONE;
         end
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Scan timing registers; wrap_q delays the wrap so o_frame lines up with digit 0.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         wrap_q <= wrap_s;
      end
   end

   // Pending register follows i_load; display register only changes at a frame wrap.
   always_comb begin
      if (i_load) begin
         pend_val_d = i_value;
         pend_dp_d  = i_dp;
      end else begin
         pend_val_d = pend_val_q;
         pend_dp_d  = pend_dp_q;
      end
      if (wrap_s) begin
         disp_val_d = pend_val_q;
         disp_dp_d  = pend_dp_q;
      end else begin
         disp_val_d = disp_val_q;
         disp_dp_d  = disp_dp_q;
      end
   end

   // Pending and display registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         disp_val_q <= '0;
         disp_dp_q  <= '0;
      end else begin
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         disp_val_q <= disp_val_d;
         disp_dp_q  <= disp_dp_d;
      end
   end

   // Select the current digit, decide blanking/duty and form the next outputs.
   always_comb begin
      nib_s    = 4'h0;
      dp_sel_s = 1'b0;
      lz_s     = 1'b0;
      an_sel_s = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            nib_s       = disp_val_q[4*k +: 4];
            dp_sel_s    = disp_dp_q[k];
            an_sel_s[k] = 1'b0;
            // Blank only when this digit and everything above it is zero.
            lz_s        = (k != 0) && ((disp_val_q >> (4*k)) == '0);
         end else begin
            an_sel_s[k] = 1'b1;
         end
      end
      blank_s = i_blank_lz && lz_s;

`ifdef SEG7_BRIGHTNESS_EN
      duty_lhs_s = {1'b0, cnt_q, 4'b0000};
      duty_rhs_s = PW'(REFRESH_DIV) * PW'({1'b0, i_bright} + 5'd1);
      on_s       = (duty_lhs_s < duty_rhs_s);
`else
      on_s       = 1'b1;
`endif

      if (on_s) begin
         an_d = an_sel_s;
         dp_d = ~dp_sel_s;
         if (blank_s) begin
            seg_d = 7'h7F;
         end else begin
            seg_d = glyph(nib_s);
         end
      end else begin
         an_d  = '1;
         dp_d  = 1'b1;
         seg_d = 7'h7F;
      end
      frame_d = wrap_q;
   end

   // Registered outputs; reset drives the display dark.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         an_q    <= '1;
         frame_q <= 1'b0;
      end else begin
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
         frame_q <= frame_d;
      end
   end

   assign o_seg   = seg_q;
   assign o_dp    = dp_q;
   assign o_an    = an_q;
   assign o_frame = frame_q;

endmodule
